// File: rtl/key_cfg_ctrl_pkg.sv
// Shared types and constants for the threshold configuration controller:
// FSM states, key events, their arbitration order and the threshold ceiling.
package key_cfg_ctrl_pkg;

  localparam int unsigned THR_W = 7;
  localparam logic [THR_W-1:0] THR_MAX = 7'd99;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_EDIT_HI,
    ST_EDIT_LO
  } state_e;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_MODE,
    EV_OK,
    EV_UP,
    EV_DOWN
  } key_event_e;

  // Highest priority first; request bit i of arbitrate() belongs to entry i.
  localparam key_event_e PRIO_ORDER [4] = '{EV_MODE, EV_OK, EV_UP, EV_DOWN};

  function automatic key_event_e arbitrate(input logic [3:0] req);
    key_event_e ev;
    ev = EV_NONE;
    for (int i = 0; i < 4; i++) begin
      if (req[i[1:0]] && (ev == EV_NONE)) begin
        ev = PRIO_ORDER[i[1:0]];
      end
    end
    return ev;
  endfunction

endpackage

// File: rtl/key_cfg_ctrl_key_filter.sv
// Push-button filter: a key held high for DEB_CNT consecutive cycles yields a
// single one-cycle pulse, then stays locked out until the key is seen low.
module key_filter #(
  parameter int DEB_CNT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic pulse
);

  localparam int CNT_W = (DEB_CNT > 1) ? $clog2(DEB_CNT + 1) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lock_q, lock_d;
  logic             pulse_q, pulse_d;

  always_comb begin
    cnt_d   = cnt_q;
    lock_d  = lock_q;
    pulse_d = 1'b0;
    if (!key) begin
      cnt_d  = '0;
      lock_d = 1'b0;
    end else if (!lock_q) begin
      if (cnt_q == CNT_W'(DEB_CNT - 1)) begin
        cnt_d   = '0;
        lock_d  = 1'b1;
        pulse_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      lock_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      lock_q  <= lock_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/key_cfg_ctrl.sv
// Water-level threshold editor: four filtered keys drive a RUN/EDIT_HI/EDIT_LO
// machine that edits shadow copies and commits them on ok, or drops them on idle timeout.
module key_cfg_ctrl
  import key_cfg_ctrl_pkg::*;
#(
  parameter int DEB_CNT = 16,
  parameter int TIMEOUT = 50_000_000,
  parameter int HI_INIT = 80,
  parameter int LO_INIT = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_mode,
  input  logic             key_up,
  input  logic             key_down,
  input  logic             key_ok,
  output logic [THR_W-1:0] thr_hi,
  output logic [THR_W-1:0] thr_lo,
  output logic             editing,
  output logic             edit_sel,
  output logic [THR_W-1:0] shadow,
  output logic             cfg_valid,
  output logic             timeout_flag
);

  localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [THR_W-1:0] HI_RST = THR_W'(HI_INIT);
  localparam logic [THR_W-1:0] LO_RST = THR_W'(LO_INIT);

  logic       pulse_mode, pulse_ok, pulse_up, pulse_down;
  key_event_e ev;

  key_filter #(.DEB_CNT(DEB_CNT)) u_filt_mode (.clk(clk), .rst(rst), .key(key_mode), .pulse(pulse_mode));
  key_filter #(.DEB_CNT(DEB_CNT)) u_filt_ok   (.clk(clk), .rst(rst), .key(key_ok),   .pulse(pulse_ok));
  key_filter #(.DEB_CNT(DEB_CNT)) u_filt_up   (.clk(clk), .rst(rst), .key(key_up),   .pulse(pulse_up));
  key_filter #(.DEB_CNT(DEB_CNT)) u_filt_down (.clk(clk), .rst(rst), .key(key_down), .pulse(pulse_down));

  // Bit order follows PRIO_ORDER so the losers of a same-cycle tie are dropped.
  assign ev = arbitrate({pulse_down, pulse_up, pulse_ok, pulse_mode});

  state_e             state_q, state_d;
  logic [THR_W-1:0]   thr_hi_q, thr_hi_d, thr_lo_q, thr_lo_d;
  logic [THR_W-1:0]   sh_hi_q, sh_hi_d, sh_lo_q, sh_lo_d;
  logic [THR_W-1:0]   shadow_q, shadow_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic               editing_q, editing_d, edit_sel_q, edit_sel_d;
  logic               cfg_valid_q, cfg_valid_d, timeout_q, timeout_d;

  always_comb begin
    state_d     = state_q;
    thr_hi_d    = thr_hi_q;
    thr_lo_d    = thr_lo_q;
    sh_hi_d     = sh_hi_q;
    sh_lo_d     = sh_lo_q;
    idle_d      = idle_q;
    cfg_valid_d = 1'b0;
    timeout_d   = 1'b0;

    if (state_q == ST_RUN) begin
      idle_d = '0;
      if (ev == EV_MODE) begin
        sh_hi_d = thr_hi_q;
        sh_lo_d = thr_lo_q;
        state_d = ST_EDIT_HI;
      end
    end else if (ev != EV_NONE) begin
      // A granted event always beats a simultaneous timeout.
      idle_d = '0;
      case (ev)
        EV_MODE: state_d = (state_q == ST_EDIT_HI) ? ST_EDIT_LO : ST_EDIT_HI;
        EV_OK: begin
          thr_hi_d    = sh_hi_q;
          thr_lo_d    = sh_lo_q;
          cfg_valid_d = 1'b1;
          state_d     = ST_RUN;
        end
        EV_UP: begin
          if (state_q == ST_EDIT_HI) begin
            if (sh_hi_q < THR_MAX) sh_hi_d = sh_hi_q + 1'b1;
          end else if ((sh_lo_q + 1'b1) < sh_hi_q) begin
            sh_lo_d = sh_lo_q + 1'b1;
          end
        end
        EV_DOWN: begin
          if (state_q == ST_EDIT_HI) begin
            if (sh_hi_q > (sh_lo_q + 1'b1)) sh_hi_d = sh_hi_q - 1'b1;
          end else if (sh_lo_q != '0) begin
            sh_lo_d = sh_lo_q - 1'b1;
          end
        end
        default: ;
      endcase
    end else if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
      idle_d    = '0;
      sh_hi_d   = thr_hi_q;
      sh_lo_d   = thr_lo_q;
      timeout_d = 1'b1;
      state_d   = ST_RUN;
    end else begin
      idle_d = idle_q + 1'b1;
    end

    editing_d  = (state_d != ST_RUN);
    edit_sel_d = (state_d == ST_EDIT_LO);
    case (state_d)
      ST_EDIT_HI: shadow_d = sh_hi_d;
      ST_EDIT_LO: shadow_d = sh_lo_d;
      default:    shadow_d = thr_hi_d;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      thr_hi_q    <= HI_RST;
      thr_lo_q    <= LO_RST;
      sh_hi_q     <= HI_RST;
      sh_lo_q     <= LO_RST;
      shadow_q    <= HI_RST;
      idle_q      <= '0;
      editing_q   <= 1'b0;
      edit_sel_q  <= 1'b0;
      cfg_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      thr_hi_q    <= thr_hi_d;
      thr_lo_q    <= thr_lo_d;
      sh_hi_q     <= sh_hi_d;
      sh_lo_q     <= sh_lo_d;
      shadow_q    <= shadow_d;
      idle_q      <= idle_d;
      editing_q   <= editing_d;
      edit_sel_q  <= edit_sel_d;
      cfg_valid_q <= cfg_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign thr_hi       = thr_hi_q;
  assign thr_lo       = thr_lo_q;
  assign editing      = editing_q;
  assign edit_sel     = edit_sel_q;
  assign shadow       = shadow_q;
  assign cfg_valid    = cfg_valid_q;
  assign timeout_flag = timeout_q;

endmodule

// File: tb/tb_key_cfg_ctrl.sv
// Directed bench for key_cfg_ctrl with short debounce and timeout so every
// scenario, including saturation and the idle timeout, runs in a few thousand cycles.
module tb_key_cfg_ctrl;

  logic       clk;
  logic       rst;
  logic       keyMode, keyUp, keyDown, keyOk;
  logic [6:0] thrHi, thrLo, shadow;
  logic       editing, editSel, cfgValid, timeoutFlag;

  int checks = 0;
  int errors = 0;
  int cfgCount = 0;
  int toCount = 0;

  key_cfg_ctrl #(
    .DEB_CNT(4),
    .TIMEOUT(64),
    .HI_INIT(80),
    .LO_INIT(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_mode(keyMode),
    .key_up(keyUp),
    .key_down(keyDown),
    .key_ok(keyOk),
    .thr_hi(thrHi),
    .thr_lo(thrLo),
    .editing(editing),
    .edit_sel(editSel),
    .shadow(shadow),
    .cfg_valid(cfgValid),
    .timeout_flag(timeoutFlag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one-cycle pulses away from the active edge.
  always @(negedge clk) begin
    if (cfgValid) cfgCount++;
    if (timeoutFlag) toCount++;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // keys = {down, up, ok, mode}; held 6 cycles then released 2 cycles.
  task automatic pressKeys(input logic [3:0] keys);
    keyMode = keys[0];
    keyOk   = keys[1];
    keyUp   = keys[2];
    keyDown = keys[3];
    repeat (6) @(negedge clk);
    keyMode = 1'b0;
    keyOk   = 1'b0;
    keyUp   = 1'b0;
    keyDown = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pressN(input logic [3:0] keys, input int n);
    for (int i = 0; i < n; i++) pressKeys(keys);
  endtask

  task automatic doReset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    doReset();
    checks++; if (thrHi !== 7'd80) begin errors++; $display("[TB] FAIL reset_thr_hi: got %0d expected 80", thrHi); end
    checks++; if (thrLo !== 7'd20) begin errors++; $display("[TB] FAIL reset_thr_lo: got %0d expected 20", thrLo); end
    checks++; if (shadow !== 7'd80) begin errors++; $display("[TB] FAIL reset_shadow: got %0d expected 80", shadow); end
    checks++; if (editing !== 1'b0) begin errors++; $display("[TB] FAIL reset_editing: got %b expected 0", editing); end
    checks++; if (editSel !== 1'b0) begin errors++; $display("[TB] FAIL reset_edit_sel: got %b expected 0", editSel); end
    checks++; if (cfgValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_cfg_valid: got %b expected 0", cfgValid); end
    checks++; if (timeoutFlag !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout: got %b expected 0", timeoutFlag); end
  endtask

  task automatic test_debounce();
    doReset();
    keyMode = 1'b1;
    repeat (3) @(negedge clk);
    keyMode = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (editing !== 1'b0) begin errors++; $display("[TB] FAIL short_press_editing: got %b expected 0", editing); end
    keyMode = 1'b1;
    repeat (10) @(negedge clk);
    keyMode = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (editing !== 1'b1) begin errors++; $display("[TB] FAIL long_press_editing: got %b expected 1", editing); end
    checks++; if (editSel !== 1'b0) begin errors++; $display("[TB] FAIL long_press_single_pulse: edit_sel got %b expected 0", editSel); end
  endtask

  task automatic test_key_held_through_reset();
    keyMode = 1'b1;
    doReset();
    repeat (2) @(negedge clk);
    checks++; if (editing !== 1'b0) begin errors++; $display("[TB] FAIL held_reset_early: editing got %b expected 0", editing); end
    repeat (3) @(negedge clk);
    checks++; if (editing !== 1'b1) begin errors++; $display("[TB] FAIL held_reset_full_count: editing got %b expected 1", editing); end
    keyMode = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_hi_saturate();
    int cfgBase;
    doReset();
    cfgBase = cfgCount;
    pressKeys(4'b0001);
    pressN(4'b0100, 25);
    checks++; if (shadow !== 7'd99) begin errors++; $display("[TB] FAIL hi_up_saturate: shadow got %0d expected 99", shadow); end
    checks++; if (thrHi !== 7'd80) begin errors++; $display("[TB] FAIL hi_uncommitted: thr_hi got %0d expected 80", thrHi); end
    pressKeys(4'b0010);
    checks++; if (thrHi !== 7'd99) begin errors++; $display("[TB] FAIL hi_commit_thr_hi: got %0d expected 99", thrHi); end
    checks++; if (thrLo !== 7'd20) begin errors++; $display("[TB] FAIL hi_commit_thr_lo: got %0d expected 20", thrLo); end
    checks++; if (editing !== 1'b0) begin errors++; $display("[TB] FAIL hi_commit_editing: got %b expected 0", editing); end
    checks++; if (cfgCount - cfgBase !== 1) begin errors++; $display("[TB] FAIL hi_commit_cfg_valid_cycles: got %0d expected 1", cfgCount - cfgBase); end
  endtask

  task automatic test_lo_saturate();
    int cfgBase;
    doReset();
    cfgBase = cfgCount;
    pressKeys(4'b0001);
    pressKeys(4'b0001);
    checks++; if (editSel !== 1'b1) begin errors++; $display("[TB] FAIL lo_edit_sel: got %b expected 1", editSel); end
    checks++; if (shadow !== 7'd20) begin errors++; $display("[TB] FAIL lo_shadow_start: got %0d expected 20", shadow); end
    pressN(4'b0100, 70);
    checks++; if (shadow !== 7'd79) begin errors++; $display("[TB] FAIL lo_up_saturate: shadow got %0d expected 79", shadow); end
    pressKeys(4'b0010);
    checks++; if (thrLo !== 7'd79) begin errors++; $display("[TB] FAIL lo_commit_thr_lo: got %0d expected 79", thrLo); end
    checks++; if (thrHi !== 7'd80) begin errors++; $display("[TB] FAIL lo_commit_thr_hi: got %0d expected 80", thrHi); end
    checks++; if (cfgCount - cfgBase !== 1) begin errors++; $display("[TB] FAIL lo_commit_cfg_valid: got %0d expected 1", cfgCount - cfgBase); end
  endtask

  task automatic test_down_saturate();
    doReset();
    pressKeys(4'b0001);
    pressN(4'b1000, 65);
    checks++; if (shadow !== 7'd21) begin errors++; $display("[TB] FAIL hi_down_saturate: shadow got %0d expected 21", shadow); end
    pressKeys(4'b0001);
    pressN(4'b1000, 25);
    checks++; if (shadow !== 7'd0) begin errors++; $display("[TB] FAIL lo_down_saturate: shadow got %0d expected 0", shadow); end
    pressKeys(4'b0001);
    checks++; if (shadow !== 7'd21) begin errors++; $display("[TB] FAIL hi_shadow_retained: got %0d expected 21", shadow); end
    pressKeys(4'b0010);
    checks++; if (thrHi !== 7'd21) begin errors++; $display("[TB] FAIL down_commit_thr_hi: got %0d expected 21", thrHi); end
    checks++; if (thrLo !== 7'd0) begin errors++; $display("[TB] FAIL down_commit_thr_lo: got %0d expected 0", thrLo); end
  endtask

  task automatic test_priority();
    int cfgBase;
    doReset();
    pressKeys(4'b0101);
    checks++; if (editing !== 1'b1) begin errors++; $display("[TB] FAIL prio_mode_up_editing: got %b expected 1", editing); end
    checks++; if (shadow !== 7'd80) begin errors++; $display("[TB] FAIL prio_mode_up_shadow: got %0d expected 80", shadow); end
    pressKeys(4'b1100);
    checks++; if (shadow !== 7'd81) begin errors++; $display("[TB] FAIL prio_up_down: shadow got %0d expected 81", shadow); end
    pressKeys(4'b0011);
    checks++; if (editSel !== 1'b1 || editing !== 1'b1) begin errors++; $display("[TB] FAIL prio_mode_ok: editing/edit_sel got %b%b expected 11", editing, editSel); end
    pressKeys(4'b0001);
    cfgBase = cfgCount;
    pressKeys(4'b0110);
    checks++; if (editing !== 1'b0) begin errors++; $display("[TB] FAIL prio_ok_up_editing: got %b expected 0", editing); end
    checks++; if (thrHi !== 7'd81) begin errors++; $display("[TB] FAIL prio_ok_up_thr_hi: got %0d expected 81", thrHi); end
    checks++; if (cfgCount - cfgBase !== 1) begin errors++; $display("[TB] FAIL prio_ok_up_cfg_valid: got %0d expected 1", cfgCount - cfgBase); end
  endtask

  task automatic test_timeout();
    int cfgBase;
    int toBase;
    int cycles;
    bit found;
    doReset();
    cfgBase = cfgCount;
    toBase  = toCount;
    pressKeys(4'b0001);
    pressN(4'b0100, 3);
    checks++; if (shadow !== 7'd83) begin errors++; $display("[TB] FAIL timeout_shadow_edit: got %0d expected 83", shadow); end
    found  = 1'b0;
    cycles = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      cycles++;
      if (timeoutFlag) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("[TB] FAIL timeout_seen: got no pulse expected pulse within 100 cycles"); end
    checks++; if (cycles < 59 || cycles > 63) begin errors++; $display("[TB] FAIL timeout_latency: got %0d cycles expected 59..63", cycles); end
    @(negedge clk);
    checks++; if (editing !== 1'b0) begin errors++; $display("[TB] FAIL timeout_state: editing got %b expected 0", editing); end
    checks++; if (thrHi !== 7'd80) begin errors++; $display("[TB] FAIL timeout_thr_hi: got %0d expected 80", thrHi); end
    checks++; if (shadow !== 7'd80) begin errors++; $display("[TB] FAIL timeout_shadow: got %0d expected 80", shadow); end
    checks++; if (cfgCount - cfgBase !== 0) begin errors++; $display("[TB] FAIL timeout_cfg_valid: got %0d expected 0", cfgCount - cfgBase); end
    checks++; if (toCount - toBase !== 1) begin errors++; $display("[TB] FAIL timeout_pulse_cycles: got %0d expected 1", toCount - toBase); end
  endtask

  task automatic test_reset_mid_edit();
    int cfgBase;
    doReset();
    cfgBase = cfgCount;
    pressKeys(4'b0001);
    pressKeys(4'b0001);
    pressN(4'b0100, 5);
    checks++; if (shadow !== 7'd25) begin errors++; $display("[TB] FAIL mid_edit_shadow: got %0d expected 25", shadow); end
    doReset();
    checks++; if (editing !== 1'b0 || editSel !== 1'b0) begin errors++; $display("[TB] FAIL mid_edit_reset_state: editing/edit_sel got %b%b expected 00", editing, editSel); end
    checks++; if (thrHi !== 7'd80 || thrLo !== 7'd20) begin errors++; $display("[TB] FAIL mid_edit_reset_thr: got %0d/%0d expected 80/20", thrHi, thrLo); end
    checks++; if (cfgCount - cfgBase !== 0) begin errors++; $display("[TB] FAIL mid_edit_reset_cfg_valid: got %0d expected 0", cfgCount - cfgBase); end
    pressKeys(4'b0001);
    pressKeys(4'b0001);
    checks++; if (shadow !== 7'd20) begin errors++; $display("[TB] FAIL mid_edit_shadow_discarded: got %0d expected 20", shadow); end
  endtask

  initial begin
    rst     = 1'b1;
    keyMode = 1'b0;
    keyUp   = 1'b0;
    keyDown = 1'b0;
    keyOk   = 1'b0;
    @(negedge clk);
    test_reset();
    test_debounce();
    test_key_held_through_reset();
    test_hi_saturate();
    test_lo_saturate();
    test_down_saturate();
    test_priority();
    test_timeout();
    test_reset_mid_edit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_cfg_ctrl.md
KEY_CFG_CTRL -- requirements
Module: key_cfg_ctrl

Interface
REQ-001 Parameter DEB_CNT, default 16: cycles a raw key must stay high before its press pulse is emitted.
REQ-002 Parameter TIMEOUT, default 50_000_000: idle cycles in an edit state before the edit is abandoned.
REQ-003 Parameter HI_INIT, default 80: reset value of the high water-level threshold (percent).
REQ-004 Parameter LO_INIT, default 20: reset value of the low water-level threshold (percent).
REQ-005 clk  input  1  system clock; all logic on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 key_mode, key_up, key_down, key_ok  input  1 each  raw active-high push-buttons.
REQ-008 thr_hi  output  7  committed high threshold, 0..99.
REQ-009 thr_lo  output  7  committed low threshold, 0..99.
REQ-010 editing  output  1  high in EDIT_HI or EDIT_LO.
REQ-011 edit_sel  output  1  0 = EDIT_HI, 1 = EDIT_LO; 0 in RUN.
REQ-012 shadow  output  7  value being edited, for display; equals thr_hi in RUN.
REQ-013 cfg_valid  output  1  one-cycle pulse when new thresholds commit.
REQ-014 timeout_flag  output  1  one-cycle pulse when an edit is abandoned on timeout.

Function
REQ-015 Each key SHALL pass through its own filter: DEB_CNT consecutive high cycles produce exactly one 1-cycle pulse; no further pulse until the key has been low for at least one cycle.
REQ-016 Simultaneous filter pulses SHALL be arbitrated by fixed priority mode > ok > up > down; lower-priority pulses in that cycle are dropped, not queued.
REQ-017 The granted event SHALL take effect on the clock edge after its filter pulse (1-cycle latency).
REQ-018 FSM states: RUN, EDIT_HI, EDIT_LO.
REQ-019 RUN + mode: copy thr_hi to sh_hi and thr_lo to sh_lo, go to EDIT_HI; up/down/ok in RUN are ignored.
REQ-020 EDIT_HI + mode: go to EDIT_LO; EDIT_LO + mode: go to EDIT_HI; shadows are retained.
REQ-021 EDIT_HI: up increments sh_hi, saturating at 99; down decrements sh_hi, saturating at sh_lo+1.
REQ-022 EDIT_LO: up increments sh_lo, saturating at sh_hi-1; down decrements sh_lo, saturating at 0.
REQ-023 Invariant sh_lo < sh_hi and thr_lo < thr_hi SHALL hold at all times.
REQ-024 ok in an edit state: thr_hi <= sh_hi, thr_lo <= sh_lo, cfg_valid pulses in the same cycle, go to RUN.
REQ-025 Idle counter: cleared on entry to an edit state and on every granted event; increments otherwise while editing.
REQ-026 When the idle counter reaches TIMEOUT-1: go to RUN, discard the shadows, leave thr_* unchanged, pulse timeout_flag.
REQ-027 If a granted event and the timeout occur in the same cycle, the event SHALL win and the counter SHALL clear.
REQ-028 shadow SHALL show sh_hi in EDIT_HI and sh_lo in EDIT_LO.

Reset
REQ-029 On rst: state RUN, thr_hi=HI_INIT, thr_lo=LO_INIT, sh_hi=HI_INIT, sh_lo=LO_INIT.
REQ-030 On rst: idle counter 0, filter counters and lockouts cleared, cfg_valid=0, timeout_flag=0, editing=0, edit_sel=0.
REQ-031 Reset mid-edit SHALL discard the shadows and SHALL NOT pulse cfg_valid.
REQ-032 A key held high through reset release SHALL require a full DEB_CNT count before it pulses.

Structure
REQ-033 A shared package SHALL hold the state enum, the priority order constant and THR_MAX=99.
REQ-034 One sub-module, key_filter (clk, rst, key, pulse; parameter DEB_CNT), SHALL be instantiated four times.
REQ-035 Arbitration, FSM, shadows and the idle timer SHALL live in key_cfg_ctrl.

Verification (DEB_CNT=4, TIMEOUT=64)
REQ-036 Hold key_mode 3 cycles then release -> no state change; hold 10 cycles -> exactly one transition RUN->EDIT_HI.
REQ-037 From reset: mode, up x25, ok -> thr_hi=99 (saturated), thr_lo=20, cfg_valid high exactly 1 cycle.
REQ-038 mode, mode, up x70 -> sh_lo saturates at 79; ok -> thr_lo=79, thr_hi=80.
REQ-039 key_up and key_mode pulse in the same cycle while in RUN -> go to EDIT_HI, shadow=80 (up dropped).
REQ-040 mode, up x3, then 64 idle cycles -> timeout_flag pulses, state RUN, thr_hi stays 80, cfg_valid never asserted.
REQ-041 rst asserted while in EDIT_LO with edited shadows -> RUN, thr_hi=80, thr_lo=20, no cfg_valid pulse.
